seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a DIGITS-wide bank of common-anode/cathode 7-segment displays.
- Accepts a packed hex value, a per-digit decimal-point mask and a per-digit blank mask; scans one digit per CLK_DIV cycles.
- Optional leading-zero suppression; double-buffered so display updates only at frame boundaries (tear-free).
- Sits between the board top and the display pins; replaces the per-digit static hex decoders.

Parameters:
- DIGITS, 8, number of digits scanned (1..16).
- CLK_DIV, 1000, clk cycles each digit is held (>=1; 1 = advance every cycle).
- ACTIVE_LOW, 1, 1 = seg/seg_dp/an driven active-low, 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  scan enable; 0 = display dark, counters hold.
- load  in  1  strobe: capture value/dp/blank into pending buffer.
- value  in  4*DIGITS  hex nibbles, nibble i = digit i (digit 0 = rightmost/LSB).
- dp  in  DIGITS  decimal point per digit.
- blank  in  DIGITS  force digit i dark (segments and dp).
- lz_en  in  1  leading-zero suppression enable.
- seg  out  7  segments, bit6=a, bit5=b ... bit0=g.
- seg_dp  out  1  decimal point segment.
- an  out  DIGITS  one-hot digit select.
- frame_done  out  1  one-cycle pulse when scan wraps to digit 0.

Behaviour:
- Reset (async, rst=1): div_cnt=0, idx=0, pending/active buffers all 0, blank buffers all 1; seg, seg_dp, an = "off" level (all 1s if ACTIVE_LOW, all 0s otherwise); frame_done=0.
- Glyphs (active-high, a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. Inverted at output when ACTIVE_LOW.
- load=1: pending <= {value, dp, blank} at posedge. Ignores en.
- Divider: when en=1, div_cnt increments; tick when div_cnt==CLK_DIV-1, then div_cnt<=0 and idx<=idx+1, wrapping DIGITS-1 -> 0.
- Frame wrap (tick with idx==DIGITS-1): active <= pending; if load is asserted the same cycle, active <= the new inputs directly (bypass). frame_done=1 for exactly the following cycle.
- Digit i is dark if active blank[i]=1, or (lz_en=1 and i!=0 and active nibbles i..DIGITS-1 all zero). Digit 0 is never zero-suppressed. Dark digit: seg and seg_dp off, an still selects it.
- lz_en is sampled live (not buffered).
- Outputs registered: seg/seg_dp/an reflect idx and active one cycle after they change; an has exactly one bit asserted while en=1.
- en=0: div_cnt and idx hold; seg, seg_dp, an forced to the off level next cycle; frame_done=0. On en=1, scan resumes from the held idx/div_cnt.
- DIGITS=1: idx constant 0; every tick is a frame wrap.
- Reset mid-frame: everything returns to reset values immediately; no partial-frame update of active.

Decomposition:
- Package seg7_pkg: the 16 glyph constants, SEG_OFF constant, function for the hex-to-glyph lookup.
- Sub-module hex_glyph: combinational 4-bit nibble -> 7-bit active-high glyph (default all off); instantiated once on the selected nibble.
- Top holds divider, scan index, double buffer, suppression logic, polarity inversion and output registers.

Test Plan:
- Reset: assert rst mid-scan -> seg=7'h7F, seg_dp=1, an=8'hFF immediately (ACTIVE_LOW=1); frame_done=0.
- Scan: CLK_DIV=4, DIGITS=4, load value=16'h12AF, en=1 -> after first frame, an cycles 1110,1101,1011,0111 every 4 clk; seg shows ~F,~A,~2,~1 (0111000,0001000,0010010,1001111); frame_done pulses once per 16 clk.
- Tear-free: load 16'h1111 then load 16'h2222 mid-frame -> current frame shows all 1s; next frame shows all 2s; same-cycle load at wrap -> new value shown in the very next frame.
- Leading zeros: value=16'h0050, lz_en=1 -> digits 3,2 dark, digit 1 shows 5, digit 0 shows 0; value=16'h0000 -> only digit 0 lit with 0.
- Blank/dp: dp=4'b0100, blank=4'b0100 -> digit 2 fully dark including dp; dp=4'b0010, blank=0 -> seg_dp asserted only while an selects digit 1.
- Enable: drop en mid-digit for 10 clk -> outputs off, idx/div_cnt frozen; re-raise -> same digit resumes with remaining count.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph table and hex-to-segment lookup for the 7-segment scan driver.
// Glyph bit order is a..g on bits 6..0, active-high.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    function automatic logic [6:0] hex_to_glyph(input logic [3:0] nib);
        logic [6:0] g;
        g = SEG_OFF;
        case (nib)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            4'hF: g = GLYPH_F;
            default: g = SEG_OFF;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_glyph.sv
// Combinational nibble to active-high a..g glyph decoder.
module hex_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph_c
);

    assign glyph_c = hex_to_glyph(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: divider, scan index, double-buffered digit
// data with frame-boundary swap, leading-zero suppression, polarity and output regs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned CLK_DIV    = 1000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam logic        OFF_LVL = ACTIVE_LOW;

    logic [DIV_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  idx;
    logic [VAL_W-1:0]  pend_value, act_value;
    logic [DIGITS-1:0] pend_dp, act_dp;
    logic [DIGITS-1:0] pend_blank, act_blank;

    logic              tick_c;
    logic              wrap_c;
    logic [3:0]        sel_nib_c;
    logic              sel_dp_c;
    logic              sel_blank_c;
    logic              sel_zero_c;
    logic              zero_run_c;
    logic [DIGITS-1:0] an_hot_c;
    logic              dark_c;
    logic [6:0]        glyph_c;
    logic [6:0]        seg_hi_c;
    logic              dp_hi_c;

    assign tick_c = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign wrap_c = tick_c && (idx == IDX_W'(DIGITS - 1));

    // Divider and scan index; both hold while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (en) begin
            if (tick_c) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Double buffer: active only changes on a frame wrap, with same-cycle load bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            act_value  <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
        end else begin
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp;
                pend_blank <= blank;
            end
            if (wrap_c) begin
                act_value <= load ? value : pend_value;
                act_dp    <= load ? dp    : pend_dp;
                act_blank <= load ? blank : pend_blank;
            end
        end
    end

    // Select the current digit and track whether it and every higher digit are zero.
    always_comb begin
        sel_nib_c   = 4'h0;
        sel_dp_c    = 1'b0;
        sel_blank_c = 1'b0;
        sel_zero_c  = 1'b0;
        zero_run_c  = 1'b1;
        an_hot_c    = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_run_c = zero_run_c && (act_value[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                sel_nib_c   = act_value[4*i +: 4];
                sel_dp_c    = act_dp[i];
                sel_blank_c = act_blank[i];
                sel_zero_c  = zero_run_c;
                an_hot_c[i] = 1'b1;
            end
        end
    end

    hex_glyph u_glyph (
        .nib     (sel_nib_c),
        .glyph_c (glyph_c)
    );

    assign dark_c   = sel_blank_c || (lz_en && (idx != '0) && sel_zero_c);
    assign seg_hi_c = dark_c ? SEG_OFF : glyph_c;
    assign dp_hi_c  = !dark_c && sel_dp_c;

    // Output registers with polarity applied; forced to the off level when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= {7{OFF_LVL}};
            seg_dp     <= OFF_LVL;
            an         <= {DIGITS{OFF_LVL}};
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap_c;
            if (en) begin
                seg    <= ACTIVE_LOW ? ~seg_hi_c : seg_hi_c;
                seg_dp <= ACTIVE_LOW ? ~dp_hi_c  : dp_hi_c;
                an     <= ACTIVE_LOW ? ~an_hot_c : an_hot_c;
            end else begin
                seg    <= {7{OFF_LVL}};
                seg_dp <= OFF_LVL;
                an     <= {DIGITS{OFF_LVL}};
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, CLK_DIV=4, active-low outputs.
module tb_seg7_scan_driver;

    localparam logic [6:0] S_OFF = 7'h7F;
    localparam logic [6:0] S_0   = 7'h01;
    localparam logic [6:0] S_1   = 7'h4F;
    localparam logic [6:0] S_2   = 7'h12;
    localparam logic [6:0] S_5   = 7'h24;
    localparam logic [6:0] S_A   = 7'h08;
    localparam logic [6:0] S_F   = 7'h38;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic        frame_done;

    int total;
    int bad;

    seg7_scan_driver #(
        .DIGITS     (4),
        .CLK_DIV    (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .lz_en      (lz_en),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until frame_done is seen; n returns the number of cycles taken.
    task automatic wait_frame(output int n);
        n = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            n++;
            if (frame_done) break;
        end
        check("frame_sync", 32'(frame_done), 32'd1);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v;
        dp    = d;
        blank = b;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // Check one full frame starting at a wrap; segs packed {d3,d2,d1,d0}, dpx active-low.
    task automatic scan_frame(input bit sync, input logic [27:0] segs, input logic [3:0] dpx,
                              input bit mid, input logic [15:0] midv);
        int n;
        int steps;
        logic [3:0] ea;
        if (sync) wait_frame(n);
        for (int d = 0; d < 4; d++) begin
            steps = (d == 0) ? 1 : 4;
            if (mid && d == 2) begin
                value = midv;
                load  = 1'b1;
                step();
                load  = 1'b0;
                steps--;
            end
            repeat (steps) step();
            ea = 4'hF;
            ea[d] = 1'b0;
            check($sformatf("an_d%0d", d), 32'(an), 32'(ea));
            check($sformatf("seg_d%0d", d), 32'(seg), 32'(segs[7*d +: 7]));
            check($sformatf("dp_d%0d", d), 32'(seg_dp), 32'(dpx[d]));
        end
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        value = 16'h0;
        dp    = 4'h0;
        blank = 4'h0;
        lz_en = 1'b0;

        #2 rst = 1'b1;
        #1;
        check("rst_seg", 32'(seg), 32'(S_OFF));
        check("rst_dp", 32'(seg_dp), 32'd1);
        check("rst_an", 32'(an), 32'hF);
        check("rst_fd", 32'(frame_done), 32'd0);
        step();
        step();
        rst = 1'b0;
        en  = 1'b1;

        // Basic scan of 12AF and frame period
        pulse_load(16'h12AF, 4'h0, 4'h0);
        scan_frame(1'b1, {S_1, S_2, S_A, S_F}, 4'hF, 1'b0, 16'h0);
        wait_frame(n);
        wait_frame(n);
        check("frame_period", 32'(n), 32'd16);

        // Tear-free: mid-frame load does not disturb the current frame
        pulse_load(16'h1111, 4'h0, 4'h0);
        scan_frame(1'b1, {S_1, S_1, S_1, S_1}, 4'hF, 1'b1, 16'h2222);
        scan_frame(1'b1, {S_2, S_2, S_2, S_2}, 4'hF, 1'b0, 16'h0);
        step();
        step();
        value = 16'h0050;
        load  = 1'b1;
        step();
        load  = 1'b0;
        check("bypass_fd", 32'(frame_done), 32'd1);
        scan_frame(1'b0, {S_0, S_0, S_5, S_0}, 4'hF, 1'b0, 16'h0);

        // Leading-zero suppression
        lz_en = 1'b1;
        scan_frame(1'b1, {S_OFF, S_OFF, S_5, S_0}, 4'hF, 1'b0, 16'h0);
        pulse_load(16'h0000, 4'h0, 4'h0);
        scan_frame(1'b1, {S_OFF, S_OFF, S_OFF, S_0}, 4'hF, 1'b0, 16'h0);
        lz_en = 1'b0;

        // Blank and decimal point
        pulse_load(16'h12AF, 4'b0100, 4'b0100);
        scan_frame(1'b1, {S_1, S_OFF, S_A, S_F}, 4'hF, 1'b0, 16'h0);
        pulse_load(16'h12AF, 4'b0010, 4'b0000);
        scan_frame(1'b1, {S_1, S_2, S_A, S_F}, 4'b1101, 1'b0, 16'h0);

        // Enable drop mid-digit then resume with the remaining count
        wait_frame(n);
        step();
        step();
        en = 1'b0;
        step();
        check("dis_seg", 32'(seg), 32'(S_OFF));
        check("dis_an", 32'(an), 32'hF);
        check("dis_dp", 32'(seg_dp), 32'd1);
        check("dis_fd", 32'(frame_done), 32'd0);
        repeat (9) step();
        check("dis_an_hold", 32'(an), 32'hF);
        en = 1'b1;
        step();
        check("res_an0", 32'(an), 32'hE);
        check("res_seg0", 32'(seg), 32'(S_F));
        step();
        check("res_an1", 32'(an), 32'hE);
        step();
        check("res_an2", 32'(an), 32'hD);
        check("res_seg2", 32'(seg), 32'(S_A));

        // Asynchronous reset mid-scan
        step();
        rst = 1'b1;
        #1;
        check("mrst_seg", 32'(seg), 32'(S_OFF));
        check("mrst_dp", 32'(seg_dp), 32'd1);
        check("mrst_an", 32'(an), 32'hF);
        check("mrst_fd", 32'(frame_done), 32'd0);
        step();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
